timer_apb_ctrl: RTL and testbench

//  APB slave front-end that sequences every bus access into the timer register file.

---
 rtl/timer_apb_ctrl.sv | 125 ++++++++++++
 tb/tb_timer_apb_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_apb_ctrl.sv
// APB slave front-end for the timer register file: runs the setup/wait/access/response
// handshake and issues single-cycle register-file strobes with merged error reporting.
module timer_apb_ctrl #(
  parameter int                ADDR_W      = 12,
  parameter int                WAIT_CYCLES = 0,
  parameter logic [ADDR_W-1:0] ADDR_MAX    = 'h1C
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  input  logic [3:0]        pstrb,
  output logic              pready,
  output logic [31:0]       prdata,
  output logic              pslverr,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wdata,
  output logic [3:0]        strb,
  input  logic [31:0]       rdata,
  input  logic              reg_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  localparam int WAIT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_write;
  logic              r_addr_err;
  logic              r_first;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_strb;
  logic              r_pready;
  logic              r_pslverr;
  logic [31:0]       r_prdata;

  logic w_addr_err;
  logic w_live;
  logic w_access;
  logic w_wr_en;
  logic w_rd_en;

  assign w_addr_err = (paddr > ADDR_MAX) | (paddr[1:0] != 2'b00);

  // penable may still be low in the very first cycle after setup; later it must hold.
  assign w_live = psel & (penable | r_first);

  // Strobes are gated by the live bus so an abort in ACCESS suppresses them the same cycle.
  assign w_access = (r_state == S_ACCESS) & w_live & ~rst;
  assign w_wr_en  = w_access &  r_write & ~r_addr_err;
  assign w_rd_en  = w_access & ~r_write & ~r_addr_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_write    <= 1'b0;
      r_addr_err <= 1'b0;
      r_first    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'h0;
      r_strb     <= 4'h0;
      r_pready   <= 1'b0;
      r_pslverr  <= 1'b0;
      r_prdata   <= 32'h0;
    end else begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= 32'h0;
      case (r_state)
        S_IDLE: begin
          if (psel && !penable) begin
            r_addr     <= paddr;
            r_write    <= pwrite;
            r_wdata    <= pwdata;
            r_strb     <= pwrite ? pstrb : 4'h0;
            r_addr_err <= w_addr_err;
            r_first    <= 1'b1;
            r_cnt      <= 4'(WAIT_LOAD);
            r_state    <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
          end
        end
        S_WAIT: begin
          r_first <= 1'b0;
          if (!w_live)
            r_state <= S_IDLE;
          else if (r_cnt == 4'd0)
            r_state <= S_ACCESS;
          else
            r_cnt <= r_cnt - 4'd1;
        end
        S_ACCESS: begin
          r_first <= 1'b0;
          if (!w_live) begin
            r_state <= S_IDLE;
          end else begin
            r_pready  <= 1'b1;
            r_pslverr <= r_addr_err | (w_wr_en & reg_err);
            r_prdata  <= w_rd_en ? rdata : 32'h0;
            r_state   <= S_RESP;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pready  = r_pready;
  assign pslverr = r_pslverr;
  assign prdata  = r_prdata;
  assign wr_en   = w_wr_en;
  assign rd_en   = w_rd_en;
  assign addr    = r_addr;
  assign wdata   = r_wdata;
  assign strb    = r_strb;

endmodule

// File: tb/tb_timer_apb_ctrl.sv
// Bench for timer_apb_ctrl: two instances (0 and 3 wait states) sharing one bus, a small
// register-file model on the back end, table vectors, a reset corner case and random traffic.
module tb_timer_apb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel0, psel3, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        reg_err;

  logic        pready0, pslverr0, wr_en0, rd_en0;
  logic [31:0] prdata0, wdata0, rdata0;
  logic [11:0] addr0;
  logic [3:0]  strb0;
  logic        pready3, pslverr3, wr_en3, rd_en3;
  logic [31:0] prdata3, wdata3, rdata3;
  logic [11:0] addr3;
  logic [3:0]  strb3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  timer_apb_ctrl #(.ADDR_W(12), .WAIT_CYCLES(0), .ADDR_MAX(12'h1C)) u_dut0 (
    .clk(clk), .rst(rst), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready0), .prdata(prdata0),
    .pslverr(pslverr0), .wr_en(wr_en0), .rd_en(rd_en0), .addr(addr0), .wdata(wdata0),
    .strb(strb0), .rdata(rdata0), .reg_err(reg_err)
  );

  timer_apb_ctrl #(.ADDR_W(12), .WAIT_CYCLES(3), .ADDR_MAX(12'h1C)) u_dut3 (
    .clk(clk), .rst(rst), .psel(psel3), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready3), .prdata(prdata3),
    .pslverr(pslverr3), .wr_en(wr_en3), .rd_en(rd_en3), .addr(addr3), .wdata(wdata3),
    .strb(strb3), .rdata(rdata3), .reg_err(reg_err)
  );

  // Register-file model: eight words, updated by the strobes unless reg_err blocks them.
  logic [31:0] mem [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
  assign rdata0 = mem[addr0[4:2]];
  assign rdata3 = mem[addr3[4:2]];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en0 && !reg_err && strb0[b]) mem[addr0[4:2]][b*8 +: 8] <= wdata0[b*8 +: 8];
      if (wr_en3 && !reg_err && strb3[b]) mem[addr3[4:2]][b*8 +: 8] <= wdata3[b*8 +: 8];
    end
  end

  // Expected register contents, updated at transaction level from the access rules.
  logic [31:0] exp_mem [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};

  logic        dut_sel;
  logic        m_pready, m_pslverr, m_wr_en, m_rd_en;
  logic [31:0] m_prdata, m_wdata;
  logic [11:0] m_addr;
  logic [3:0]  m_strb;

  always_comb begin
    m_pready  = dut_sel ? pready3  : pready0;
    m_pslverr = dut_sel ? pslverr3 : pslverr0;
    m_wr_en   = dut_sel ? wr_en3   : wr_en0;
    m_rd_en   = dut_sel ? rd_en3   : rd_en0;
    m_prdata  = dut_sel ? prdata3  : prdata0;
    m_wdata   = dut_sel ? wdata3   : wdata0;
    m_addr    = dut_sel ? addr3    : addr0;
    m_strb    = dut_sel ? strb3    : strb0;
  end

  typedef struct {
    bit          sel3;
    bit          w;
    logic [11:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    bit          rerr;
    int          drop;
    bit          exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [18];
  int   n_xfer = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
    end
  endtask

  // One APB transfer; drop>0 releases psel from that cycle on to abort it.
  task automatic xfer(input bit sel3, input bit w, input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit rerr, input int drop,
                      input bit exp_err, input logic [31:0] exp_rd);
    int          wst = sel3 ? 3 : 0;
    bit          aerr = (a > 12'h1C) || (a[1:0] != 2'b00);
    bit          exp_strobe = !aerr && (drop == 0);
    int          last = (drop != 0) ? 3 + wst : 2 + wst;
    int          n_wr = 0, n_rd = 0, n_pr = 0, n_both = 0;
    int          st_at = -1, pr_at = -1;
    logic        got_err = 1'b0;
    logic [31:0] got_rd = 32'h0, got_wd = 32'h0;
    logic [11:0] got_addr = 12'h0;
    logic [3:0]  got_strb = 4'h0;
    dut_sel = sel3;
    reg_err = rerr;
    for (int j = 0; j <= last; j++) begin
      @(negedge clk);
      if (j == 0) begin
        psel0 = 1'b0; psel3 = 1'b0;
        if (sel3) psel3 = 1'b1; else psel0 = 1'b1;
        penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
      end else if (drop != 0 && j >= drop) begin
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
      end else begin
        penable = 1'b1;
      end
      #1;
      if (m_wr_en) begin n_wr++; st_at = j; end
      if (m_rd_en) begin n_rd++; st_at = j; end
      if (m_wr_en && m_rd_en) n_both++;
      if (m_pready) begin
        n_pr++; pr_at = j; got_err = m_pslverr; got_rd = m_prdata;
        got_addr = m_addr; got_strb = m_strb; got_wd = m_wdata;
      end
    end
    chk("wr_en_count", n_wr, (w && exp_strobe) ? 1 : 0);
    chk("rd_en_count", n_rd, (!w && exp_strobe) ? 1 : 0);
    chk("strobe_overlap", n_both, 0);
    if (exp_strobe) chk("strobe_cycle", st_at, 1 + wst);
    chk("pready_count", n_pr, (drop == 0) ? 1 : 0);
    if (drop == 0) begin
      chk("pready_cycle", pr_at, 2 + wst);
      chk("pslverr", {31'h0, got_err}, {31'h0, exp_err});
      chk("prdata", got_rd, exp_rd);
      chk("addr_latch", {20'h0, got_addr}, {20'h0, a});
      chk("strb_latch", {28'h0, got_strb}, {28'h0, (w ? s : 4'h0)});
      if (w) chk("wdata_latch", got_wd, d);
    end
    if (w && !aerr && !rerr && drop == 0)
      for (int b = 0; b < 4; b++)
        if (s[b]) exp_mem[a[4:2]][b*8 +: 8] = d[b*8 +: 8];
    $display("xfer %0d wait=%0d %s addr=0x%03h strb=%h drop=%0d pready_at=%0d pslverr=%0b prdata=0x%08h",
             n_xfer, wst, w ? "WR" : "RD", a, s, drop, pr_at, got_err, got_rd);
    n_xfer++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 12'h0; pwdata = 32'h0; pstrb = 4'h0; reg_err = 1'b0; dut_sel = 1'b0;

    tbl[0]  = '{0, 1, 12'h000, 32'h0000_0103, 4'hF, 0, 0, 0, 32'h0};
    tbl[1]  = '{0, 0, 12'h000, 32'h0,         4'hF, 1, 0, 0, 32'h0000_0103};
    tbl[2]  = '{0, 0, 12'h010, 32'h0,         4'h0, 0, 0, 0, 32'hFFFF_FFFF};
    tbl[3]  = '{0, 0, 12'h020, 32'h0,         4'h0, 0, 0, 1, 32'h0};
    tbl[4]  = '{0, 1, 12'h006, 32'hDEAD_BEEF, 4'hF, 0, 0, 1, 32'h0};
    tbl[5]  = '{0, 1, 12'h000, 32'h0000_0303, 4'hF, 1, 0, 1, 32'h0};
    tbl[6]  = '{0, 0, 12'h000, 32'h0,         4'h0, 0, 0, 0, 32'h0000_0103};
    tbl[7]  = '{0, 1, 12'h008, 32'hAABB_CCDD, 4'h5, 0, 0, 0, 32'h0};
    tbl[8]  = '{0, 0, 12'h008, 32'h0,         4'h0, 0, 0, 0, 32'h00BB_00DD};
    tbl[9]  = '{0, 1, 12'h00C, 32'h1234_5678, 4'h0, 0, 0, 0, 32'h0};
    tbl[10] = '{0, 0, 12'h00C, 32'h0,         4'h0, 0, 0, 0, 32'h0};
    tbl[11] = '{0, 1, 12'h01C, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 32'h0};
    tbl[12] = '{0, 0, 12'h01C, 32'h0,         4'h0, 0, 0, 0, 32'hCAFE_F00D};
    tbl[13] = '{1, 0, 12'h014, 32'h0,         4'h0, 0, 0, 0, 32'h0};
    tbl[14] = '{1, 0, 12'h014, 32'h0,         4'h0, 0, 2, 0, 32'h0};
    tbl[15] = '{1, 1, 12'h018, 32'h0000_0055, 4'hF, 0, 0, 0, 32'h0};
    tbl[16] = '{1, 0, 12'h018, 32'h0,         4'h0, 0, 0, 0, 32'h0000_0055};
    tbl[17] = '{0, 0, 12'h01D, 32'h0,         4'h0, 0, 0, 1, 32'h0};

    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctrl0", {28'h0, pready0, pslverr0, wr_en0, rd_en0}, 32'h0);
    chk("reset_ctrl3", {28'h0, pready3, pslverr3, wr_en3, rd_en3}, 32'h0);
    chk("reset_prdata", prdata0 | prdata3, 32'h0);
    chk("reset_latches", {8'h0, addr0, strb0, 4'h0, addr3[3:0]} | wdata0 | {28'h0, strb3}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++)
      xfer(tbl[i].sel3, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].rerr, tbl[i].drop,
           tbl[i].exp_err, tbl[i].exp_rd);

    // Reset while the 3-wait-state instance sits in WAIT: transfer must vanish.
    begin
      int n_ev = 0;
      dut_sel = 1'b1;
      @(negedge clk);
      psel0 = 1'b0; psel3 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h014;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midreset_ctrl", {28'h0, pready3, pslverr3, wr_en3, rd_en3}, 32'h0);
      chk("midreset_addr", {20'h0, addr3}, 32'h0);
      chk("midreset_data", prdata3 | wdata3 | {28'h0, strb3}, 32'h0);
      for (int j = 0; j < 6; j++) begin
        @(negedge clk);
        #1;
        if (pready3 || wr_en3 || rd_en3) n_ev++;
      end
      chk("midreset_no_strobe", n_ev, 0);
      $display("xfer %0d wait=3 RD addr=0x014 reset during wait, events_after=%0d", n_xfer, n_ev);
      n_xfer++;
    end
    xfer(1, 0, 12'h018, 32'h0, 4'h0, 0, 0, 0, exp_mem[6]);

    for (int k = 0; k < 40; k++) begin
      bit          sel3 = 1'($urandom_range(0, 1));
      bit          w    = 1'($urandom_range(0, 1));
      int          r    = $urandom_range(0, 7);
      logic [11:0] a;
      logic [31:0] d    = $urandom;
      logic [3:0]  s    = 4'($urandom_range(0, 15));
      bit          rerr = ($urandom_range(0, 3) == 0);
      int          drop = ($urandom_range(0, 7) == 0) ? $urandom_range(1, sel3 ? 4 : 1) : 0;
      bit          aerr;
      if (r == 0)      a = 12'(12'h20 + 4 * $urandom_range(0, 7));
      else if (r == 1) a = 12'(4 * $urandom_range(0, 7) + $urandom_range(1, 3));
      else             a = 12'(4 * $urandom_range(0, 7));
      aerr = (a > 12'h1C) || (a[1:0] != 2'b00);
      xfer(sel3, w, a, d, s, rerr, drop, aerr || (w && rerr),
           (!w && !aerr) ? exp_mem[a[4:2]] : 32'h0);
    end

    @(negedge clk);
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
